dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory interface.
- Serves the MEM-stage read/write request from the CPU and holds the pipeline through stall_o while a multi-cycle access completes.
- Returns read data with a registered valid strobe.
- Backing store is an internal word array, so the CPU can run against a slow memory model in place of the single-cycle data memory.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with pipeline stall
//
// Purpose : Serves the MEM-stage load/store against an internal word array.
//           Each access takes LATENCY cycles, and stall_o holds the pipeline
//           for that time. Loads return data with a registered one-cycle
//           rvalid_o strobe.
// Macro   : DMEM_WRITE_BUFFER_EN enables a one-entry posted write buffer.
//           With the buffer, stores complete with zero stall and drain to the
//           array in the background. Loads forward from the buffer.
// Ports   : clk_i    - clock, rising edge
//           rst_i    - asynchronous active-low reset
//           req_i    - MEM stage holds a valid load/store
//           we_i     - 1 = store, 0 = load
//           addr_i   - byte address; word index = addr_i[AW+1:2], upper bits alias
//           wdata_i  - store data
//           stall_o  - freezes upstream pipeline registers while high
//           rdata_o  - registered load data, held until the next completing load
//           rvalid_o - one-cycle strobe for a completing load
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          accept;     // request enters the IDLE/BUSY/DONE path this edge
    logic          acc_fire;   // edge that moves into DONE and performs the access
    logic          unused_addr_bits;

    assign idx              = addr_i[AW+1:2];
    assign unused_addr_bits = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_WRITE_BUFFER_EN
    logic          wb_valid;
    logic [AW-1:0] wb_idx;
    logic [31:0]   wb_data;
    logic [CW-1:0] wb_cnt;
    logic          wb_capture;
    logic          wb_drain;

    // A store is posted only into an empty buffer; a store arriving while the
    // buffer is full waits in IDLE (stalled) until the drain has emptied it.
    assign wb_capture = (state == IDLE) && req_i && we_i && !wb_valid;
    assign wb_drain   = wb_valid && (wb_cnt == '0);
    assign accept     = (state == IDLE) && req_i && !we_i;
`else
    assign accept     = (state == IDLE) && req_i;
`endif

    assign acc_fire = (accept && (LATENCY == 1)) ||
                      ((state == BUSY) && (cnt == CNT_ONE));

    // State register and registered read path
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == BUSY) begin
                cnt <= cnt - CNT_ONE;
            end
            rvalid_o <= acc_fire && !we_i;
            if (acc_fire && !we_i) begin
`ifdef DMEM_WRITE_BUFFER_EN
                // Forward the posted store, including in its drain cycle.
                if (wb_valid && (wb_idx == idx)) begin
                    rdata_o <= wb_data;
                end else begin
                    rdata_o <= mem[idx];
                end
`else
                rdata_o <= mem[idx];
`endif
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY == 1) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall_o = 1'b0;
        case (state)
`ifdef DMEM_WRITE_BUFFER_EN
            IDLE:    stall_o = req_i && (!we_i || wb_valid);
`else
            IDLE:    stall_o = req_i;
`endif
            BUSY:    stall_o = 1'b1;
            DONE:    stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
    end

`ifdef DMEM_WRITE_BUFFER_EN
    // Posted write buffer: holds one store for LATENCY cycles before draining.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_data  <= '0;
            wb_cnt   <= '0;
        end else if (wb_capture) begin
            wb_valid <= 1'b1;
            wb_idx   <= idx;
            wb_data  <= wdata_i;
            wb_cnt   <= CNT_INIT;
        end else if (wb_drain) begin
            wb_valid <= 1'b0;
        end else if (wb_valid) begin
            wb_cnt <= wb_cnt - CNT_ONE;
        end
    end

    // The array has no reset; rst_i gates the write so that a reset edge
    // cannot commit a pending store.
    always_ff @(posedge clk_i) begin
        if (rst_i && wb_drain) begin
            mem[wb_idx] <= wb_data;
        end
    end
`else
    // The array has no reset; rst_i gates the write so that an access
    // aborted by reset never reaches the array.
    always_ff @(posedge clk_i) begin
        if (rst_i && acc_fire && we_i) begin
            mem[idx] <= wdata_i;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        req4, we4;
    logic [31:0] addr4, wdata4;
    logic        stall4, rvalid4;
    logic [31:0] rdata4;

    logic        req1, we1;
    logic [31:0] addr1, wdata1;
    logic        stall1, rvalid1;
    logic [31:0] rdata1;

    int checks;
    int errors;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req4),
        .we_i     (we4),
        .addr_i   (addr4),
        .wdata_i  (wdata4),
        .stall_o  (stall4),
        .rdata_o  (rdata4),
        .rvalid_o (rvalid4)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req1),
        .we_i     (we1),
        .addr_i   (addr1),
        .wdata_i  (wdata1),
        .stall_o  (stall1),
        .rdata_o  (rdata1),
        .rvalid_o (rvalid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete access on the selected instance (sel=1: LATENCY=1, sel=0: LATENCY=4).
    // Counts stall cycles from the request cycle up to DONE, then checks the
    // response strobe and data and that the strobe lasts a single cycle.
    task automatic access(input bit sel, input logic st, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        int  n_stall;
        int  exp_stall;
        bit  done;
        logic s, v;
        logic [31:0] r;
        exp_stall = sel ? 1 : 4;
        @(posedge clk);
        #1;
        if (sel) begin req1 = 1'b1; we1 = st; addr1 = a; wdata1 = d; end
        else     begin req4 = 1'b1; we4 = st; addr4 = a; wdata4 = d; end
        n_stall = 0;
        done    = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            s = sel ? stall1 : stall4;
            if (s) n_stall++;
            else   done = 1'b1;
        end
        check(st ? "store_stall_cycles" : "load_stall_cycles", n_stall, exp_stall);
        v = sel ? rvalid1 : rvalid4;
        r = sel ? rdata1 : rdata4;
        check(st ? "store_rvalid" : "load_rvalid", {31'd0, v}, {31'd0, !st});
        if (!st) check("load_rdata", r, exp_rd);
        @(posedge clk);
        #1;
        if (sel) req1 = 1'b0;
        else     req4 = 1'b0;
        @(negedge clk);
        v = sel ? rvalid1 : rvalid4;
        s = sel ? stall1 : stall4;
        check("rvalid_after_done", {31'd0, v}, 32'd0);
        check("stall_after_done", {31'd0, s}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        req4 = 1'b0; we4 = 1'b0; addr4 = '0; wdata4 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'd0, stall4}, 32'd0);
        check("reset_rvalid", {31'd0, rvalid4}, 32'd0);
        check("reset_rdata", rdata4, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Store then load, LATENCY=4
        access(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);

        // Aliasing: 0x404 maps to word 1, as do 0x004 and 0x007
        access(1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 32'h0);
        access(1'b0, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5);
        access(1'b0, 1'b0, 32'h0000_0007, 32'h0, 32'hA5A5_A5A5);

        // LATENCY=1: store immediately followed by load
        access(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1234_5678);

        // Reset in the second BUSY cycle of a store to 0x20 holding 0x55
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0055, 32'h0);
        @(posedge clk);
        #1;
        req4 = 1'b1; we4 = 1'b1; addr4 = 32'h0000_0020; wdata4 = 32'h0000_0001;
        @(posedge clk);   // enters BUSY
        @(posedge clk);   // second BUSY cycle
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall_follows_req_hi", {31'd0, stall4}, 32'd1);
        req4 = 1'b0;
        #1;
        check("rst_mid_stall_follows_req_lo", {31'd0, stall4}, 32'd0);
        check("rst_mid_rvalid", {31'd0, rvalid4}, 32'd0);
        check("rst_mid_rdata", rdata4, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        access(1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0055);

        // Idle hold: outputs stay quiet and rdata_o keeps the last load value
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_stall", {31'd0, stall4}, 32'd0);
            check("idle_rvalid", {31'd0, rvalid4}, 32'd0);
            check("idle_rdata", rdata4, 32'h0000_0055);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
